// File: rtl/fp_prf_multiport.sv
// fp_prf_multiport: FP physical register file with round-robin writeback arbitration and ready scoreboard
module fp_prf_multiport #(
  parameter int REG_SIZE       = 36,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64,
  parameter int NUM_RD         = 6,
  parameter int NUM_WB         = 4,
  parameter int NUM_WR         = 2,
  parameter int NUM_ALLOC      = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_RD*REG_SIZE_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]              rd_data_o,
  output logic [NUM_RD-1:0]                   rd_ready_o,
  input  logic [NUM_WB-1:0]                   wb_valid_i,
  input  logic [NUM_WB*REG_SIZE_WIDTH-1:0]    wb_addr_i,
  input  logic [NUM_WB*XLEN-1:0]              wb_data_i,
  output logic [NUM_WB-1:0]                   wb_ready_o,
  input  logic [NUM_ALLOC-1:0]                alloc_valid_i,
  input  logic [NUM_ALLOC*REG_SIZE_WIDTH-1:0] alloc_addr_i
);
  localparam int W  = REG_SIZE_WIDTH;
  localparam int PW = NUM_WB > 1 ? $clog2(NUM_WB) : 1;
  logic [XLEN-1:0]     regs_q [REG_SIZE];
  logic [XLEN-1:0]     regs_d [REG_SIZE];
  logic [XLEN-1:0]     regs_n [REG_SIZE];
  logic [REG_SIZE-1:0] rdy_q, rdy_d, rdy_n;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_WB-1:0]   grant;
  logic [NUM_WR-1:0]   slot_vld;
  int                  slot_src [NUM_WR];

  // p0 (when hardwired) and out-of-range addresses hold no state
  function automatic logic ok(input logic [W-1:0] a);
    return (int'(a) < REG_SIZE) && !(ZERO_REG != 0 && a == '0);
  endfunction

  always_comb begin
    int n, idx;
    grant    = '0;
    slot_vld = '0;
    rr_ptr_d = rr_ptr_q;
    n        = 0;
    for (int s = 0; s < NUM_WR; s++) slot_src[s] = 0;
    for (int i = 0; i < NUM_WB; i++) begin
      idx = int'(rr_ptr_q) + i;
      idx = idx >= NUM_WB ? idx - NUM_WB : idx;
      if (!rst && wb_valid_i[idx] && n < NUM_WR) begin
        grant[idx]  = 1'b1;
        slot_src[n] = idx;
        slot_vld[n] = 1'b1;
        rr_ptr_d    = PW'((idx + 1) % NUM_WB);
        n           = n + 1;
      end
    end
  end

  assign wb_ready_o = grant;

  // regs_n/rdy_n are the post-edge view without reset; they double as the bypass source
  always_comb begin
    logic [W-1:0] a;
    regs_n = regs_q;
    rdy_n  = rdy_q;
    a      = '0;
    for (int s = 0; s < NUM_WR; s++) begin
      a = wb_addr_i[slot_src[s]*W +: W];
      if (slot_vld[s] && ok(a)) begin
        regs_n[a] = wb_data_i[slot_src[s]*XLEN +: XLEN];
        rdy_n[a]  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_ALLOC; j++) begin
      a = alloc_addr_i[j*W +: W];
      if (!rst && alloc_valid_i[j] && ok(a)) rdy_n[a] = 1'b0;
    end
    for (int r = 0; r < REG_SIZE; r++) regs_d[r] = rst ? '0 : regs_n[r];
    rdy_d = rst ? '1 : rdy_n;
  end

  always_comb begin
    logic [W-1:0] a;
    rd_data_o  = '0;
    rd_ready_o = '1;
    a          = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rd_addr_i[k*W +: W];
      if (ok(a)) begin
        rd_data_o[k*XLEN +: XLEN] = BYPASS != 0 ? regs_n[a] : regs_q[a];
        rd_ready_o[k]             = BYPASS != 0 ? rdy_n[a] : rdy_q[a];
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q   <= regs_d;
    rdy_q    <= rdy_d;
    rr_ptr_q <= rst ? '0 : rr_ptr_d;
  end
endmodule

// File: tb/tb_fp_prf_multiport.sv
// tb_fp_prf_multiport: directed checks of arbitration, bypass, scoreboard, zero-reg and reset
module tb_fp_prf_multiport;
  logic         clk = 1'b0;
  logic         rst;
  logic [35:0]  rd_addr;
  logic [383:0] rd_data;
  logic [5:0]   rd_ready;
  logic [3:0]   wb_valid;
  logic [23:0]  wb_addr;
  logic [255:0] wb_data;
  logic [3:0]   wb_ready;
  logic [1:0]   alloc_valid;
  logic [11:0]  alloc_addr;
  int           passed = 0;
  int           total  = 0;

  fp_prf_multiport dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_ready_o(rd_ready),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setrd(input int k, input int a);
    rd_addr[k*6 +: 6] = 6'(a);
  endtask

  task automatic wb(input int s, input int a, input logic [63:0] d);
    wb_valid[s]        = 1'b1;
    wb_addr[s*6 +: 6]  = 6'(a);
    wb_data[s*64 +: 64] = d;
  endtask

  function automatic logic [63:0] rdd(input int k);
    return rd_data[k*64 +: 64];
  endfunction

  initial begin
    rst = 1'b1; wb_valid = 4'hf; wb_addr = '0; wb_data = '0;
    alloc_valid = '0; alloc_addr = '0;
    for (int k = 0; k < 6; k++) setrd(k, 5);
    #2 chk("rst_wb_ready", 64'(wb_ready), 64'h0);
    tick(); tick();
    for (int k = 0; k < 6; k++) chk("rst_rd_data", rdd(k), 64'h0);
    chk("rst_rd_ready", 64'(rd_ready), 64'h3f);
    wb_valid = '0; rst = 1'b0;
    alloc_valid = 2'b01; alloc_addr[5:0] = 6'd7;
    tick();
    alloc_valid = '0; setrd(0, 7);
    #1 chk("alloc_p7_ready", 64'(rd_ready[0]), 64'h0);
    wb(2, 7, 64'hDEAD);
    #1 chk("p7_grant", 64'(wb_ready), 64'h4);
    chk("p7_bypass_data", rdd(0), 64'hDEAD);
    chk("p7_bypass_ready", 64'(rd_ready[0]), 64'h1);
    tick();
    wb_valid = '0;
    #1 chk("p7_array_data", rdd(0), 64'hDEAD);
    chk("p7_array_ready", 64'(rd_ready[0]), 64'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int s = 0; s < 4; s++) wb(s, 10 + s, 64'hA0 + 64'(s));
    #1 chk("rr_grant_c0", 64'(wb_ready), 64'h3);
    tick();
    chk("rr_grant_c1", 64'(wb_ready), 64'hc);
    tick();
    chk("rr_grant_c2", 64'(wb_ready), 64'h3);
    tick();
    wb_valid = '0;
    for (int k = 0; k < 4; k++) setrd(k, 10 + k);
    #1 for (int k = 0; k < 4; k++) chk("rr_data", rdd(k), 64'hA0 + 64'(k));
    rst = 1'b1; tick(); rst = 1'b0;
    wb(0, 9, 64'hC0); wb(3, 9, 64'hC3);
    #1 chk("p9_grant", 64'(wb_ready), 64'h9);
    tick();
    wb_valid = '0; setrd(0, 9);
    #1 chk("p9_slot1_wins", rdd(0), 64'hC3);
    wb(2, 16, 64'hB2);
    #1 chk("src2_grant", 64'(wb_ready), 64'h4);
    tick();
    wb_valid = '0;
    wb(3, 17, 64'hB3); wb(0, 18, 64'hB0); wb(1, 15, 64'hB1);
    #1 chk("src1_blocked", 64'(wb_ready), 64'h9);
    tick();
    wb_valid[3] = 1'b0; wb_valid[0] = 1'b0;
    #1 chk("src1_held_grant", 64'(wb_ready), 64'h2);
    tick();
    wb_valid = '0;
    setrd(0, 15); setrd(1, 16); setrd(2, 17); setrd(3, 18);
    #1 chk("p15_data", rdd(0), 64'hB1);
    chk("p16_data", rdd(1), 64'hB2);
    chk("p17_data", rdd(2), 64'hB3);
    chk("p18_data", rdd(3), 64'hB0);
    wb(0, 0, 64'h1234); setrd(0, 0);
    #1 chk("p0_grant", 64'(wb_ready), 64'h1);
    chk("p0_bypass_data", rdd(0), 64'h0);
    tick();
    wb_valid = '0;
    #1 chk("p0_data", rdd(0), 64'h0);
    chk("p0_ready", 64'(rd_ready[0]), 64'h1);
    alloc_valid = 2'b01; alloc_addr[5:0] = 6'd0;
    tick();
    alloc_valid = '0;
    #1 chk("p0_alloc_ready", 64'(rd_ready[0]), 64'h1);
    wb(1, 40, 64'hFF); setrd(1, 40);
    #1 chk("oor_grant", 64'(wb_ready), 64'h2);
    chk("oor_data", rdd(1), 64'h0);
    chk("oor_ready", 64'(rd_ready[1]), 64'h1);
    tick();
    wb_valid = '0;
    alloc_valid = 2'b01; alloc_addr[5:0] = 6'd4;
    wb(1, 4, 64'h55); setrd(0, 4);
    #1 chk("p4_grant", 64'(wb_ready), 64'h2);
    chk("p4_bypass_data", rdd(0), 64'h55);
    chk("p4_bypass_ready", 64'(rd_ready[0]), 64'h0);
    tick();
    wb_valid = '0; alloc_valid = '0;
    #1 chk("p4_data", rdd(0), 64'h55);
    chk("p4_ready", 64'(rd_ready[0]), 64'h0);
    for (int s = 0; s < 4; s++) wb(s, 20 + s, 64'hE0 + 64'(s));
    rst = 1'b1;
    #1 chk("midrst_wb_ready", 64'(wb_ready), 64'h0);
    tick();
    rst = 1'b0; wb_valid = '0;
    setrd(0, 4); setrd(1, 9); setrd(2, 20);
    #1 chk("midrst_p4_data", rdd(0), 64'h0);
    chk("midrst_p4_ready", 64'(rd_ready[0]), 64'h1);
    chk("midrst_p9_data", rdd(1), 64'h0);
    chk("midrst_p20_data", rdd(2), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
